// File: rtl/shift_reg_universal.sv
// Universal shift register (hold / shift right / shift left / parallel load) with a frame counter.
// Define SHIFT_REG_ROTATE_EN to let the rotate input recirculate the outgoing bit during shifts.
module shift_reg_universal #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             sdi_r,
   input  logic             sdi_l,
   input  logic             rotate,
   input  logic [WIDTH-1:0] pdata,
   output logic [WIDTH-1:0] q,
   output logic             sdo_r,
   output logic             sdo_l,
   output logic             frame_done
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   localparam logic [1:0] MODE_HOLD  = 2'b00;
   localparam logic [1:0] MODE_RIGHT = 2'b01;
   localparam logic [1:0] MODE_LEFT  = 2'b10;
   localparam logic [1:0] MODE_LOAD  = 2'b11;

   logic [CNT_W-1:0] cnt;
   logic             ins_r;
   logic             ins_l;
   logic             shift;

`ifdef SHIFT_REG_ROTATE_EN
   assign ins_r = rotate ? q[0]       : sdi_r;
   assign ins_l = rotate ? q[WIDTH-1] : sdi_l;
`else
   logic unused_rotate;
   assign unused_rotate = rotate;
   assign ins_r = sdi_r;
   assign ins_l = sdi_l;
`endif

   assign shift = en && (mode == MODE_RIGHT || mode == MODE_LEFT);
   assign sdo_r = q[0];
   assign sdo_l = q[WIDTH-1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q          <= '0;
         cnt        <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (en) begin
            case (mode)
               MODE_RIGHT: q <= {ins_r, q[WIDTH-1:1]};
               MODE_LEFT:  q <= {q[WIDTH-2:0], ins_l};
               MODE_LOAD: begin
                  q   <= pdata;
                  cnt <= '0;
               end
               default: ;
            endcase
         end
         // Both directions advance the same frame counter; the pulse lands the cycle after the last shift.
         if (shift) begin
            if (cnt == CNT_LAST) begin
               cnt        <= '0;
               frame_done <= 1'b1;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule
